// File: rtl/dac_sample_scheduler.sv
// Paced two-requester sample scheduler feeding the DAC driver's data_in.
// A rate divider opens one handshake slot per tick; missing data holds the output and is counted.
module dac_sample_scheduler #(
   parameter int DATA_W = 16,
   parameter int DIV_W  = 16,
   parameter int CNT_W  = 16
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              enable,
   input  logic [1:0]        mode,
   input  logic [DIV_W-1:0]  rate_div,
   input  logic              clr_status,
   input  logic [DATA_W-1:0] ch0_data,
   input  logic              ch0_valid,
   input  logic [DATA_W-1:0] ch1_data,
   input  logic              ch1_valid,
   output logic              ch0_ready,
   output logic              ch1_ready,
   output logic [DATA_W-1:0] dac_data,
   output logic              dac_valid,
   output logic              underrun,
   output logic [CNT_W-1:0]  underrun_cnt,
   output logic              busy
);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   state_t            state_reg, state_next;
   logic [DIV_W-1:0]  cnt_reg;
   logic              rr_reg;
   logic              tick, accept, miss;
   logic [DATA_W-1:0] sample;
   logic [DATA_W:0]   sum_wide;

   assign sum_wide = {ch0_data[DATA_W-1], ch0_data} + {ch1_data[DATA_W-1], ch1_data};

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state_reg <= S_IDLE;
      else            state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (enable)  state_next = S_RUN;
         S_RUN:   if (!enable) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      tick      = (state_reg == S_RUN) && enable && (cnt_reg >= rate_div);
      ch0_ready = 1'b0;
      ch1_ready = 1'b0;
      accept    = 1'b0;
      sample    = ch0_data;
      if (tick) begin
         case (mode)
            2'd0: begin
               ch0_ready = 1'b1;
               accept    = ch0_valid;
               sample    = ch0_data;
            end
            2'd1: begin
               ch1_ready = 1'b1;
               accept    = ch1_valid;
               sample    = ch1_data;
            end
            2'd2: begin
               // No fallback: a stalled channel keeps the turn until it delivers.
               ch0_ready = !rr_reg;
               ch1_ready = rr_reg;
               accept    = rr_reg ? ch1_valid : ch0_valid;
               sample    = rr_reg ? ch1_data : ch0_data;
            end
            default: begin
               ch0_ready = ch0_valid && ch1_valid;
               ch1_ready = ch0_valid && ch1_valid;
               accept    = ch0_valid && ch1_valid;
               if (sum_wide[DATA_W] != sum_wide[DATA_W-1])
                  sample = sum_wide[DATA_W] ? SAT_MIN : SAT_MAX;
               else
                  sample = sum_wide[DATA_W-1:0];
            end
         endcase
      end
      miss = tick && !accept;
      busy = (state_reg == S_RUN);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_reg   <= '0;
         rr_reg    <= 1'b0;
         dac_data  <= '0;
         dac_valid <= 1'b0;
      end else if (state_reg == S_IDLE || !enable) begin
         cnt_reg   <= '0;
         rr_reg    <= 1'b0;
         dac_data  <= '0;
         dac_valid <= 1'b0;
      end else begin
         cnt_reg   <= tick ? '0 : cnt_reg + DIV_W'(1);
         dac_valid <= accept;
         if (accept) dac_data <= sample;
         if (accept && mode == 2'd2) rr_reg <= !rr_reg;
      end
   end

   // A clear that lands on a missed tick restarts the count at that miss.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         underrun     <= 1'b0;
         underrun_cnt <= '0;
      end else if (clr_status) begin
         underrun     <= miss;
         underrun_cnt <= miss ? CNT_W'(1) : '0;
      end else if (miss) begin
         underrun <= 1'b1;
         if (!(&underrun_cnt)) underrun_cnt <= underrun_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/dac_sample_scheduler.md
# dac_sample_scheduler

Paced sample scheduler that sits upstream of the AD9744 DAC driver and shares its 16-bit signed `data_in` port between two sample requesters. A programmable divider generates the DAC update rate; on each rate tick the block pulls one sample (or a saturated sum) from the requesters over a valid/ready handshake. If the required data is missing, it holds the last value and records an underrun.

## Interface
- `DATA_W`, 16: sample width, two's complement; `dac_data` drives the DAC driver's `data_in`.
- `DIV_W`, 16: width of the rate divider.
- `CNT_W`, 16: width of the underrun counter.

- `sys_clk`  in  1  single clock, rising edge.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  1 = run, 0 = idle / mute.
- `mode`  in  2  0 = ch0 only, 1 = ch1 only, 2 = alternate ch0/ch1, 3 = saturated sum ch0+ch1.
- `rate_div`  in  DIV_W  tick period is `rate_div`+1 cycles.
- `clr_status`  in  1  clears `underrun` and `underrun_cnt`.
- `ch0_data`, `ch1_data`  in  DATA_W  requester samples, signed.
- `ch0_valid`, `ch1_valid`  in  1  requester sample available.
- `ch0_ready`, `ch1_ready`  out  1  sample accepted when valid&ready; combinational.
- `dac_data`  out  DATA_W  registered sample to the DAC driver, signed.
- `dac_valid`  out  1  one-cycle pulse: `dac_data` updated this cycle.
- `underrun`  out  1  sticky flag.
- `underrun_cnt`  out  CNT_W  saturating count of missed ticks.
- `busy`  out  1  state == RUN.

## Operation
- **Reset values:** FSM IDLE, divider `cnt`=0, `rr`=0 (points at ch0), and every output 0.
- **FSM IDLE:**
  - `cnt` is held at 0.
  - Both readies are 0.
  - `dac_data` is forced to 0.
  - Moves to RUN on the next edge while `enable`=1.
- **FSM RUN:**
  - `cnt` increments each cycle.
  - `tick` = (`cnt` >= `rate_div`) & `enable`. On a tick, `cnt` returns to 0.
  - `enable`=0 in RUN: no tick and no ready that cycle. Next edge goes to IDLE, `dac_data` becomes 0, `rr` becomes 0, and `dac_valid` stays 0.
- **Per tick, by `mode` (sampled in the tick cycle):**
  - Mode 0 or 1: ready of the selected channel = 1. If valid, `dac_data` <= that channel's sample. Otherwise it is an underrun.
  - Mode 2: ready of channel `rr` = 1. If valid, the sample is accepted and `rr` toggles. Otherwise it is an underrun and `rr` does not toggle; there is no fallback to the other channel.
  - Mode 3: both readies = ch0_valid & ch1_valid. If both are valid, `dac_data` <= sat(ch0_data + ch1_data). Otherwise it is an underrun and neither channel is consumed.
- **Saturation:** the sum is taken at DATA_W+1 bits and clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- **On underrun:**
  - `dac_data` holds its previous value.
  - `dac_valid` = 0.
  - `underrun` <= 1.
  - `underrun_cnt` increments, saturating at all-ones.
- **`clr_status`:** takes effect on the next edge. If it coincides with an underrun tick, the result is `underrun`=1 and `underrun_cnt`=1.
- **Readies outside a tick are 0.** A requester may hold valid indefinitely.
- **Live `rate_div` changes:** if `rate_div` is lowered below the current `cnt`, the comparison is >=, so the tick fires on the next RUN cycle.

## Timing
- **First tick:** occurs in the (`rate_div`+1)th cycle after IDLE→RUN.
- **Steady rate:** one tick every `rate_div`+1 cycles. `rate_div`=0 gives a tick every cycle.
- **Latency:** `dac_data` and `dac_valid` update at the edge closing the tick cycle, one cycle after the handshake.
- **`dac_valid`:** high for exactly one cycle per accepted tick.
- **Asynchronous reset mid-operation:** all outputs clear immediately and any handshake in flight is not consumed.

## Test plan
- **Mode 0, steady rate:**
  - Stimulus: `rate_div`=3, ch0 always valid with 100, 200, 300.
  - Required: a `dac_valid` pulse every 4 cycles, first pulse at the 5th edge after `enable`. `dac_data` = 100, 200, 300. `ch1_ready` is never 1.
- **Mode 2, alternation and stall:**
  - Stimulus: `rate_div`=0, ch0 = 10, 11; ch1 = -10, with ch1_valid dropped for one tick.
  - Required: output 10, -10, 11. The dropped tick holds the last value, gives `underrun`=1 and `underrun_cnt`=1, and `rr` stays on ch1.
- **Mode 3, saturation:**
  - Stimulus: 30000 + 10000, then -30000 + -10000, then 5 + -7.
  - Required: 32767, -32768, -2.
  - Then drop ch0_valid for one tick: neither ready is asserted, `dac_data` stays -2, and the underrun is counted.
- **Enable drop and status clear:**
  - Stimulus: deassert `enable` mid-period.
  - Required: no ready in that cycle; next edge gives `busy`=0 and `dac_data`=0. Re-enabling restarts with a full `rate_div`+1 delay.
  - Stimulus: `clr_status` coincident with an underrun.
  - Required: `underrun`=1, `underrun_cnt`=1.
- **Counter saturation and reset:**
  - Stimulus: force 2^CNT_W+3 underruns.
  - Required: `underrun_cnt` = all-ones.
  - Stimulus: assert `sys_rst_n` low between edges.
  - Required: every output 0 immediately.
